disp_regctrl_ml: RTL

//  Next-generation display register block. Serves NLAYER frame-buffer layers from the same 16-bit register bus.

---
 rtl/disp_regctrl_ml.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/disp_regctrl_ml.sv
// Multi-layer display register block: pending layer state committed to the fetch units at VSYNC.
// Optional frame counter at 0x00C is built only when DISP_FRAMECNT_EN is defined.
module disp_regctrl_ml #(
    parameter int unsigned NLAYER = 2,
    parameter int unsigned AW     = 29
) (
    input  logic                 ACLK,
    input  logic                 ARST_X,
    input  logic                 DSP_VSYNC_X,
    input  logic [15:0]          WRADDR,
    input  logic [3:0]           BYTEEN,
    input  logic                 WREN,
    input  logic [31:0]          WDATA,
    input  logic [15:0]          RDADDR,
    input  logic                 RDEN,
    output logic [31:0]          RDATA,
    output logic                 DISPON,
    output logic [NLAYER*AW-1:0] DISPADDR,
    output logic [NLAYER-1:0]    LAYEREN,
    output logic                 DSP_IRQ,
    input  logic [NLAYER-1:0]    BUF_UNDER,
    input  logic [NLAYER-1:0]    BUF_OVER
);

    logic                 vs_s1_q, vs_s2_q, vs_s3_q, vs_fall;
    logic                 dispon_q, dispon_d;
    logic [1:0]           inten_q, inten_d;
    logic [2:0]           stat_q, stat_d, w1c;
    logic                 cp_q, cp_d;
    logic [AW-1:0]        pend_addr_q [NLAYER];
    logic [AW-1:0]        pend_addr_d [NLAYER];
    logic [NLAYER-1:0]    pend_en_q, pend_en_d;
    logic [NLAYER*AW-1:0] act_addr_q, act_addr_d;
    logic [NLAYER-1:0]    act_en_q, act_en_d;
    logic                 irq_q, irq_d;
    logic [31:0]          rdata_q, rdata_d, rd_val;
    logic [15:0]          framecnt;

    logic                 wr_hit, rd_hit, wr_lay, rd_lay, layer_wr;
    logic [9:0]           wr_off, rd_off;
    logic [3:0]           wr_layer, rd_layer;
    logic [1:0]           wr_sel, rd_sel;
    logic [31:0]          wr_old, wr_merged;

    assign wr_hit   = WREN && (WRADDR[15:12] == 4'h0);
    assign wr_off   = WRADDR[11:2];
    assign wr_lay   = (wr_off[9:6] == 4'h1);
    assign wr_layer = wr_off[5:2];
    assign wr_sel   = wr_off[1:0];
    assign rd_hit   = (RDADDR[15:12] == 4'h0);
    assign rd_off   = RDADDR[11:2];
    assign rd_lay   = (rd_off[9:6] == 4'h1);
    assign rd_layer = rd_off[5:2];
    assign rd_sel   = rd_off[1:0];

    // Falling edge of the synchronised VSYNC_X.
    assign vs_fall = vs_s3_q & ~vs_s2_q;

    function automatic logic [31:0] be_merge(input logic [31:0] old, input logic [31:0] nw,
                                             input logic [3:0] be);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[b*8 +: 8] = be[b] ? nw[b*8 +: 8] : old[b*8 +: 8];
        end
        return r;
    endfunction

    always_comb begin
        wr_old = '0;
        for (int n = 0; n < int'(NLAYER); n++) begin
            if (int'(wr_layer) == n) wr_old[AW-1:0] = pend_addr_q[n];
        end
        wr_merged = be_merge(wr_old, WDATA, BYTEEN);
    end

    always_comb begin
        dispon_d    = dispon_q;
        inten_d     = inten_q;
        pend_addr_d = pend_addr_q;
        pend_en_d   = pend_en_q;
        layer_wr    = 1'b0;

        if (wr_hit && wr_off == 10'd0 && BYTEEN[0]) dispon_d = WDATA[0];
        if (wr_hit && wr_off == 10'd1 && BYTEEN[0]) inten_d  = WDATA[1:0];

        for (int n = 0; n < int'(NLAYER); n++) begin
            if (wr_hit && wr_lay && int'(wr_layer) == n) begin
                if (wr_sel == 2'd0) begin
                    pend_addr_d[n] = wr_merged[AW-1:0];
                    layer_wr       = 1'b1;
                end else if (wr_sel == 2'd1) begin
                    layer_wr = 1'b1;
                    if (BYTEEN[0]) pend_en_d[n] = WDATA[0];
                end
            end
        end

        // Display off: active tracks pending directly. Display on: copy the pre-write pending
        // state at vs_fall, so a coinciding write stays pending for the next frame.
        act_addr_d = act_addr_q;
        act_en_d   = act_en_q;
        cp_d       = cp_q | layer_wr;
        if (!dispon_q) begin
            for (int n = 0; n < int'(NLAYER); n++) act_addr_d[n*AW +: AW] = pend_addr_d[n];
            act_en_d = pend_en_d;
            cp_d     = 1'b0;
        end else if (vs_fall) begin
            for (int n = 0; n < int'(NLAYER); n++) act_addr_d[n*AW +: AW] = pend_addr_q[n];
            act_en_d = pend_en_q;
            cp_d     = layer_wr;
        end

        w1c       = (wr_hit && wr_off == 10'd2 && BYTEEN[0]) ? WDATA[2:0] : 3'b000;
        stat_d[0] = vs_fall     | (stat_q[0] & ~w1c[0]);
        stat_d[1] = |BUF_UNDER  | (stat_q[1] & ~w1c[1]);
        stat_d[2] = |BUF_OVER   | (stat_q[2] & ~w1c[2]);

        irq_d = (stat_q[0] & inten_q[0]) | ((stat_q[1] | stat_q[2]) & inten_q[1]);
    end

    always_comb begin
        rd_val = '0;
        if (rd_hit) begin
            case (rd_off)
                10'd0:   rd_val[0]    = dispon_q;
                10'd1:   rd_val[1:0]  = inten_q;
                10'd2:   rd_val[3:0]  = {cp_q, stat_q};
                10'd3:   rd_val[15:0] = framecnt;
                default: begin
                    for (int n = 0; n < int'(NLAYER); n++) begin
                        if (rd_lay && int'(rd_layer) == n) begin
                            if (rd_sel == 2'd0)      rd_val[AW-1:0] = pend_addr_q[n];
                            else if (rd_sel == 2'd1) rd_val[0]      = pend_en_q[n];
                        end
                    end
                end
            endcase
        end
        rdata_d = RDEN ? rd_val : rdata_q;
    end

    always_ff @(posedge ACLK or negedge ARST_X) begin
        if (!ARST_X) begin
            vs_s1_q    <= 1'b1;
            vs_s2_q    <= 1'b1;
            vs_s3_q    <= 1'b1;
            dispon_q   <= 1'b0;
            inten_q    <= '0;
            stat_q     <= '0;
            cp_q       <= 1'b0;
            for (int n = 0; n < int'(NLAYER); n++) pend_addr_q[n] <= '0;
            pend_en_q  <= '0;
            act_addr_q <= '0;
            act_en_q   <= '0;
            irq_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            vs_s1_q    <= DSP_VSYNC_X;
            vs_s2_q    <= vs_s1_q;
            vs_s3_q    <= vs_s2_q;
            dispon_q   <= dispon_d;
            inten_q    <= inten_d;
            stat_q     <= stat_d;
            cp_q       <= cp_d;
            pend_addr_q <= pend_addr_d;
            pend_en_q  <= pend_en_d;
            act_addr_q <= act_addr_d;
            act_en_q   <= act_en_d;
            irq_q      <= irq_d;
            rdata_q    <= rdata_d;
        end
    end

`ifdef DISP_FRAMECNT_EN
    logic [15:0] fc_q, fc_d;

    // A clear coinciding with an increment wins.
    always_comb begin
        fc_d = fc_q;
        if (wr_hit && wr_off == 10'd3) fc_d = '0;
        else if (vs_fall && dispon_q)  fc_d = fc_q + 16'd1;
    end

    always_ff @(posedge ACLK or negedge ARST_X) begin
        if (!ARST_X) fc_q <= '0;
        else         fc_q <= fc_d;
    end

    assign framecnt = fc_q;
`else
    assign framecnt = '0;
`endif

    assign RDATA    = rdata_q;
    assign DISPON   = dispon_q;
    assign DISPADDR = act_addr_q;
    assign LAYEREN  = act_en_q;
    assign DSP_IRQ  = irq_q;

    logic unused;
    assign unused = ^{WRADDR[1:0], RDADDR[1:0], wr_merged};

endmodule
